// File: rtl/hdmi_cfg_sequencer.sv
// hdmi_cfg_sequencer: AXI4-Lite master that writes NUM_REGS config words
// into the hdmi_interface register bank, reads them back and reports status.
module hdmi_cfg_sequencer #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int NUM_REGS = 4,
   parameter logic [C_M_AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                                     ACLK,
   input  logic                                     ARESETN,
   input  logic                                     start,
   input  logic [NUM_REGS*C_M_AXI_DATA_WIDTH-1:0]   cfg_data,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     error,
   output logic [1:0]                               err_code,
   output logic [3:0]                               err_index,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_AWADDR,
   output logic [2:0]                               M_AXI_AWPROT,
   output logic                                     M_AXI_AWVALID,
   input  logic                                     M_AXI_AWREADY,
   output logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_WDATA,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]          M_AXI_WSTRB,
   output logic                                     M_AXI_WVALID,
   input  logic                                     M_AXI_WREADY,
   input  logic [1:0]                               M_AXI_BRESP,
   input  logic                                     M_AXI_BVALID,
   output logic                                     M_AXI_BREADY,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]            M_AXI_ARADDR,
   output logic [2:0]                               M_AXI_ARPROT,
   output logic                                     M_AXI_ARVALID,
   input  logic                                     M_AXI_ARREADY,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]            M_AXI_RDATA,
   input  logic [1:0]                               M_AXI_RRESP,
   input  logic                                     M_AXI_RVALID,
   output logic                                     M_AXI_RREADY
);

   localparam int DW = C_M_AXI_DATA_WIDTH;
   localparam int IW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WR      = 3'd1;
   localparam logic [2:0] S_WR_RESP = 3'd2;
   localparam logic [2:0] S_RD      = 3'd3;
   localparam logic [2:0] S_RD_RESP = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;
   localparam logic [2:0] S_ABORT   = 3'd6;

   logic [2:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] snap_q [NUM_REGS];
   logic [DW-1:0] snap_d [NUM_REGS];
   logic          awvalid_q, awvalid_d;
   logic          wvalid_q, wvalid_d;
   logic          arvalid_q, arvalid_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          error_q, error_d;
   logic [1:0]    err_code_q, err_code_d;
   logic [3:0]    err_index_q, err_index_d;

   logic          ab;
   logic [1:0]    ab_code;
   logic          tmo;
   logic          last;
   logic          aw_ok;
   logic          w_ok;

   // Next-state and output-register logic for the write/readback sequence
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      snap_d      = snap_q;
      awvalid_d   = awvalid_q;
      wvalid_d    = wvalid_q;
      arvalid_d   = arvalid_q;
      busy_d      = busy_q;
      done_d      = done_q;
      error_d     = error_q;
      err_code_d  = err_code_q;
      err_index_d = err_index_q;
      ab          = 1'b0;
      ab_code     = 2'b00;
      tmo         = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
      last        = (idx_q == IW'(NUM_REGS - 1));
      aw_ok       = !awvalid_q || M_AXI_AWREADY;
      w_ok        = !wvalid_q || M_AXI_WREADY;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               for (int i = 0; i < NUM_REGS; i++) begin
                  snap_d[i] = cfg_data[i*DW +: DW];
               end
               idx_d       = '0;
               cnt_d       = '0;
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_code_d  = 2'b00;
               err_index_d = 4'd0;
               busy_d      = 1'b1;
               awvalid_d   = 1'b1;
               wvalid_d    = 1'b1;
               state_d     = S_WR;
            end
         end
         S_WR: begin
            if (awvalid_q && M_AXI_AWREADY) awvalid_d = 1'b0;
            if (wvalid_q && M_AXI_WREADY) wvalid_d = 1'b0;
            if (aw_ok && w_ok) begin
               cnt_d   = '0;
               state_d = S_WR_RESP;
            end else if (tmo) begin
               ab      = 1'b1;
               ab_code = 2'b11;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_WR_RESP: begin
            if (M_AXI_BVALID) begin
               cnt_d = '0;
               if (M_AXI_BRESP != 2'b00) begin
                  ab      = 1'b1;
                  ab_code = 2'b01;
               end else if (last) begin
                  idx_d     = '0;
                  arvalid_d = 1'b1;
                  state_d   = S_RD;
               end else begin
                  idx_d     = idx_q + IW'(1);
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = S_WR;
               end
            end else if (tmo) begin
               ab      = 1'b1;
               ab_code = 2'b11;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RD: begin
            if (M_AXI_ARREADY) begin
               arvalid_d = 1'b0;
               cnt_d     = '0;
               state_d   = S_RD_RESP;
            end else if (tmo) begin
               ab      = 1'b1;
               ab_code = 2'b11;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_RD_RESP: begin
            if (M_AXI_RVALID) begin
               cnt_d = '0;
               if (M_AXI_RRESP != 2'b00) begin
                  ab      = 1'b1;
                  ab_code = 2'b01;
               end else if (M_AXI_RDATA != snap_q[idx_q]) begin
                  ab      = 1'b1;
                  ab_code = 2'b10;
               end else if (last) begin
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
                  state_d = S_FINISH;
               end else begin
                  idx_d     = idx_q + IW'(1);
                  arvalid_d = 1'b1;
                  state_d   = S_RD;
               end
            end else if (tmo) begin
               ab      = 1'b1;
               ab_code = 2'b11;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         S_FINISH: state_d = S_IDLE;
         S_ABORT:  state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
      if (ab) begin
         state_d     = S_ABORT;
         error_d     = 1'b1;
         err_code_d  = ab_code;
         err_index_d = 4'(idx_q);
         busy_d      = 1'b0;
         awvalid_d   = 1'b0;
         wvalid_d    = 1'b0;
         arvalid_d   = 1'b0;
      end
   end

   // State and output registers, cleared asynchronously mid-transaction too
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         cnt_q       <= '0;
         snap_q      <= '{default: '0};
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_code_q  <= 2'b00;
         err_index_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         snap_q      <= snap_d;
         awvalid_q   <= awvalid_d;
         wvalid_q    <= wvalid_d;
         arvalid_q   <= arvalid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
         err_index_q <= err_index_d;
      end
   end

   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign err_code      = err_code_q;
   assign err_index     = err_index_q;
   assign M_AXI_AWADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
   assign M_AXI_ARADDR  = BASE_ADDR + C_M_AXI_ADDR_WIDTH'({idx_q, 2'b00});
   assign M_AXI_AWPROT  = 3'b000;
   assign M_AXI_ARPROT  = 3'b000;
   assign M_AXI_WSTRB   = '1;
   assign M_AXI_WDATA   = snap_q[idx_q];
   assign M_AXI_AWVALID = awvalid_q;
   assign M_AXI_WVALID  = wvalid_q;
   assign M_AXI_ARVALID = arvalid_q;
   assign M_AXI_BREADY  = (state_q == S_WR_RESP);
   assign M_AXI_RREADY  = (state_q == S_RD_RESP);

endmodule

// File: tb/tb_hdmi_cfg_sequencer.sv
// tb_hdmi_cfg_sequencer: AXI4-Lite slave model plus scoreboard for the
// config sequencer; expected beats and status are queued at stimulus time.
`timescale 1ns/1ps
module tb_hdmi_cfg_sequencer;

   localparam int NR  = 4;
   localparam int TMO = 16;

   typedef struct {
      logic       d;
      logic       e;
      logic [1:0] code;
      logic [3:0] idx;
      int         lat;
      int         arrun;
   } st_t;

   logic ACLK = 1'b0;
   logic ARESETN = 1'b1;
   logic start = 1'b0;
   logic [NR*32-1:0] cfg_data = '0;
   logic busy, done, error;
   logic [1:0] err_code;
   logic [3:0] err_index;
   logic [31:0] awaddr, araddr, wdata;
   logic [2:0] awprot, arprot;
   logic [3:0] wstrb;
   logic awvalid, awready, wvalid, wready;
   logic bvalid, bready, arvalid, arready, rvalid, rready;
   logic [1:0] bresp, rresp;
   logic [31:0] rdata;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   int aw_dly = 0, w_dly = 0, bad_b = -1, bad_r = -1;
   logic ar_block = 1'b0;

   int aw_cnt, w_cnt;
   logic aw_got, w_got, b_pend, r_pend;
   logic [31:0] a_sav, w_sav, r_addr;
   logic [3:0] b_idx;
   logic [31:0] mem [16];

   logic [31:0] exp_aw [$];
   logic [31:0] exp_w [$];
   logic [31:0] exp_ar [$];
   st_t exp_st [$];

   hdmi_cfg_sequencer #(
      .C_M_AXI_ADDR_WIDTH(32), .C_M_AXI_DATA_WIDTH(32), .NUM_REGS(NR),
      .BASE_ADDR(32'h0), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .cfg_data(cfg_data),
      .busy(busy), .done(done), .error(error),
      .err_code(err_code), .err_index(err_index),
      .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot),
      .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
      .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb),
      .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
      .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
      .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot),
      .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
      .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp),
      .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
   );

   always #5 ACLK = ~ACLK;
   always @(posedge ACLK) cyc <= cyc + 1;

   wire aw_hs = awvalid & awready;
   wire w_hs  = wvalid & wready;
   wire ar_hs = arvalid & arready;
   wire [31:0] wa_now = aw_hs ? awaddr : a_sav;
   wire [31:0] wd_now = w_hs ? wdata : w_sav;

   assign awready = (aw_cnt >= aw_dly);
   assign wready  = (w_cnt >= w_dly);
   assign arready = !ar_block;

   // Slave: B/R responses appear one full cycle after the request completes
   always @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         aw_cnt <= 0; w_cnt <= 0;
         aw_got <= 1'b0; w_got <= 1'b0;
         b_pend <= 1'b0; r_pend <= 1'b0;
         bvalid <= 1'b0; rvalid <= 1'b0;
         bresp <= 2'b00; rresp <= 2'b00;
         rdata <= '0; a_sav <= '0; w_sav <= '0;
         r_addr <= '0; b_idx <= '0;
      end else begin
         if (aw_hs) aw_cnt <= 0;
         else if (awvalid) aw_cnt <= aw_cnt + 1;
         if (w_hs) w_cnt <= 0;
         else if (wvalid) w_cnt <= w_cnt + 1;
         if ((aw_hs || aw_got) && (w_hs || w_got)) begin
            aw_got <= 1'b0;
            w_got <= 1'b0;
            b_pend <= 1'b1;
            mem[wa_now[5:2]] <= wd_now;
            b_idx <= wa_now[5:2];
         end else begin
            if (aw_hs) begin aw_got <= 1'b1; a_sav <= awaddr; end
            if (w_hs) begin w_got <= 1'b1; w_sav <= wdata; end
         end
         if (b_pend) begin
            bvalid <= 1'b1;
            bresp <= (int'(b_idx) == bad_b) ? 2'b10 : 2'b00;
            b_pend <= 1'b0;
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
         if (ar_hs) begin r_pend <= 1'b1; r_addr <= araddr; end
         if (r_pend) begin
            rvalid <= 1'b1;
            rresp <= 2'b00;
            rdata <= (int'(r_addr[5:2]) == bad_r) ? 32'hDEADBEEF
                                                  : mem[r_addr[5:2]];
            r_pend <= 1'b0;
         end else if (rvalid && rready) begin
            rvalid <= 1'b0;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic miss(input string name);
      checks++;
      failures++;
      $display("FAIL %s actual=unexpected required=none", name);
   endtask

   function automatic st_t mk(input logic d, input logic e,
                              input logic [1:0] c, input logic [3:0] i,
                              input int lat, input int ar);
      st_t s;
      s.d = d; s.e = e; s.code = c; s.idx = i; s.lat = lat; s.arrun = ar;
      return s;
   endfunction

   logic pb = 1'b0, par = 1'b0;
   int t_busy = 0, ar_run = 0;
   st_t st;

   // Monitor: pop and compare on every handshake and on each sequence end
   always @(negedge ACLK) begin
      if (!ARESETN) begin
         pb = 1'b0; par = 1'b0; ar_run = 0;
      end else begin
         if (aw_hs) begin
            if (exp_aw.size() == 0) miss("aw_beat");
            else chk("awaddr", awaddr, exp_aw.pop_front());
            chk("awprot", awprot, 3'b000);
         end
         if (w_hs) begin
            if (exp_w.size() == 0) miss("w_beat");
            else chk("wdata", wdata, exp_w.pop_front());
            chk("wstrb", wstrb, 4'hF);
         end
         if (ar_hs) begin
            if (exp_ar.size() == 0) miss("ar_beat");
            else chk("araddr", araddr, exp_ar.pop_front());
            chk("arprot", arprot, 3'b000);
         end
         if (arvalid) ar_run = par ? ar_run + 1 : 1;
         par = arvalid;
         if (busy && !pb) t_busy = cyc;
         if (!busy && pb) begin
            if (exp_st.size() == 0) begin
               miss("status");
            end else begin
               st = exp_st.pop_front();
               chk("done", done, st.d);
               chk("error", error, st.e);
               chk("err_code", err_code, st.code);
               chk("err_index", err_index, st.idx);
               if (st.lat > 0) chk("latency", cyc - t_busy + 1, st.lat);
               if (st.arrun > 0) chk("arvalid_cycles", ar_run, st.arrun);
            end
         end
         pb = busy;
      end
   end

   task automatic run_seq(input logic [NR*32-1:0] cfg, input int nwr,
                          input int nrd, input st_t s);
      for (int i = 0; i < nwr; i++) begin
         exp_aw.push_back(32'(i * 4));
         exp_w.push_back(cfg[i*32 +: 32]);
      end
      for (int i = 0; i < nrd; i++) exp_ar.push_back(32'(i * 4));
      exp_st.push_back(s);
      @(negedge ACLK);
      cfg_data = cfg;
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      cfg_data = ~cfg;
   endtask

   task automatic wait_end(input string name, input logic exp_done);
      int n = 0;
      while (exp_st.size() != 0 && n < 400) begin
         @(negedge ACLK);
         n++;
      end
      if (exp_st.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=running required=finished", name);
         exp_st.delete();
      end
      repeat (3) @(negedge ACLK);
      chk({name, "_leftover"}, exp_aw.size() + exp_w.size() + exp_ar.size(),
          0);
      chk({name, "_sticky"}, {busy, done, error}, {1'b0, exp_done, !exp_done});
      exp_aw.delete(); exp_w.delete(); exp_ar.delete();
   endtask

   logic [NR*32-1:0] c1, c2, c3;
   logic pbr;
   int nb;

   initial begin
      c1 = {32'h4, 32'h3, 32'h2, 32'h1};
      c2 = {32'hA5A5_0004, 32'h1234_5678, 32'h0BAD_F00D, 32'h8000_0001};
      c3 = {32'h0000_00FF, 32'hFFFF_0000, 32'h5555_AAAA, 32'h0F0F_F0F0};
      #3 ARESETN = 1'b0;
      #5;
      chk("reset_outputs",
          {busy, done, error, err_code, err_index,
           awvalid, wvalid, bready, arvalid, rready}, '0);
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      repeat (2) @(negedge ACLK);

      run_seq(c1, 4, 4, mk(1'b1, 1'b0, 2'b00, 4'd0, 25, 0));
      wait_end("zero_wait", 1'b1);

      aw_dly = 3;
      run_seq(c2, 4, 4, mk(1'b1, 1'b0, 2'b00, 4'd0, 0, 0));
      @(negedge ACLK);
      chk("w_drops_aw_holds", {awvalid, wvalid}, 2'b10);
      wait_end("aw_delay", 1'b1);
      aw_dly = 0;

      w_dly = 3;
      run_seq(c3, 4, 4, mk(1'b1, 1'b0, 2'b00, 4'd0, 0, 0));
      @(negedge ACLK);
      chk("aw_drops_w_holds", {awvalid, wvalid}, 2'b01);
      wait_end("w_delay", 1'b1);
      w_dly = 0;

      bad_b = 2;
      run_seq(c2, 3, 0, mk(1'b0, 1'b1, 2'b01, 4'd2, 0, 0));
      wait_end("bad_bresp", 1'b0);
      bad_b = -1;

      bad_r = 3;
      run_seq(c1, 4, 4, mk(1'b0, 1'b1, 2'b10, 4'd3, 0, 0));
      wait_end("mismatch", 1'b0);
      bad_r = -1;

      ar_block = 1'b1;
      run_seq(c3, 4, 0, mk(1'b0, 1'b1, 2'b11, 4'd0, 0, TMO));
      wait_end("ar_timeout", 1'b0);
      ar_block = 1'b0;

      run_seq(c2, 4, 4, mk(1'b1, 1'b0, 2'b00, 4'd0, 0, 0));
      nb = 0;
      pbr = 1'b0;
      for (int n = 0; n < 100 && nb < 2; n++) begin
         @(negedge ACLK);
         if (bready && !pbr) nb++;
         pbr = bready;
      end
      chk("reached_wr_resp_1", nb, 2);
      #1 ARESETN = 1'b0;
      #1;
      chk("async_reset_outputs",
          {busy, done, error, err_code, err_index,
           awvalid, wvalid, bready, arvalid, rready}, '0);
      exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_st.delete();
      @(negedge ACLK);
      @(negedge ACLK);
      ARESETN = 1'b1;
      @(negedge ACLK);
      run_seq(c1, 4, 4, mk(1'b1, 1'b0, 2'b00, 4'd0, 25, 0));
      wait_end("after_reset", 1'b1);

      run_seq(c3, 4, 4, mk(1'b1, 1'b0, 2'b00, 4'd0, 25, 0));
      repeat (4) @(negedge ACLK);
      cfg_data = c2;
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      repeat (10) @(negedge ACLK);
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
      wait_end("start_busy", 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hdmi_cfg_sequencer.md
Name: hdmi_cfg_sequencer

Overview:
- AXI4-Lite master that programs the hdmi_interface slave register bank (NUM_REGS 32-bit registers at BASE_ADDR + 4*i) from a parallel configuration word.
- Reads every register back and compares it with the value written.
- Reports done/error status to the system controller.
- Sits between the system controller and the hdmi_interface S00_AXI port. It replaces software bring-up writes with a hardware start pulse.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32: width of AWADDR/ARADDR.
- C_M_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- NUM_REGS, 4: number of registers programmed; range 1..16.
- BASE_ADDR, 32'h0000_0000: address of register 0.
- TIMEOUT_CYCLES, 1024: maximum wait per handshake phase before abort; must be >= 2.

Ports:
- ACLK  in  1  clock; all logic on rising edge.
- ARESETN  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle request to run the sequence; ignored while busy=1.
- cfg_data  in  NUM_REGS*32  register values; register i is at bits [32*i+31:32*i]; sampled when start is accepted.
- busy  out  1  high from the cycle after start is accepted until the sequence ends.
- done  out  1  sticky; high after a successful sequence; cleared when start is accepted.
- error  out  1  sticky; high after an aborted sequence; cleared when start is accepted.
- err_code  out  2  00 none, 01 bad BRESP/RRESP, 10 readback mismatch, 11 timeout.
- err_index  out  4  register index at which the abort occurred.
- M_AXI_AWADDR, M_AXI_AWPROT(3), M_AXI_AWVALID  out; M_AXI_AWREADY  in.
- M_AXI_WDATA(32), M_AXI_WSTRB(4), M_AXI_WVALID  out; M_AXI_WREADY  in.
- M_AXI_BRESP(2), M_AXI_BVALID  in; M_AXI_BREADY  out.
- M_AXI_ARADDR, M_AXI_ARPROT(3), M_AXI_ARVALID  out; M_AXI_ARREADY  in.
- M_AXI_RDATA(32), M_AXI_RRESP(2), M_AXI_RVALID  in; M_AXI_RREADY  out.

Behaviour:
- Reset values: all outputs 0, state IDLE, index 0, timeout counter 0. Assertion of ARESETN=0 clears everything asynchronously, including valids in the middle of a transaction.
- Constant outputs: AWPROT=ARPROT=3'b000, WSTRB=4'hF.
- Address: AWADDR/ARADDR = BASE_ADDR + 4*idx, computed modulo 2^C_M_AXI_ADDR_WIDTH.
- WDATA is the word for idx from the cfg_data snapshot.
- States: IDLE, WR, WR_RESP, RD, RD_RESP, FINISH, ABORT.
- IDLE: if start=1, capture cfg_data, set idx=0, clear done/error/err_code/err_index, and go to WR. AWVALID and WVALID rise on the next cycle, together with busy.
- WR: hold AWVALID and WVALID. Each one drops the cycle after its own handshake (VALID&READY). The two handshakes may complete in either order or in the same cycle. Once both are done, go to WR_RESP.
- WR_RESP: BREADY=1.
  - On BVALID with BRESP==00: if idx==NUM_REGS-1, set idx=0 and go to RD; otherwise increment idx and go to WR.
  - On BVALID with BRESP!=00: go to ABORT with err_code 01.
- RD: hold ARVALID until ARREADY, then go to RD_RESP.
- RD_RESP: RREADY=1.
  - On RVALID with RRESP!=00: err_code 01.
  - On RVALID with RDATA != snapshot[idx]: err_code 10. Bad RRESP takes priority over mismatch.
  - On RVALID with neither error: if idx is the last index, go to FINISH; otherwise increment idx and go to RD.
- Latency with a zero-wait slave (READY already high, response one cycle after the handshake): 3 cycles per write beat and 3 cycles per read beat. Total from start to done is 6*NUM_REGS+1 cycles; 25 for NUM_REGS=4.
- Timeout: the counter clears on entry to WR, WR_RESP, RD and RD_RESP, and increments each cycle without completion. When it reaches TIMEOUT_CYCLES, go to ABORT with err_code 11. All valids drop in that cycle; this is a deliberate fault-abort exception to the AXI valid-hold rule.
- FINISH: done=1, busy=0, return to IDLE.
- ABORT: error=1, err_code latched, err_index=idx, busy=0, all valids and readies 0, return to IDLE.
- A new start in the same cycle as the IDLE return is not accepted; start is only sampled in IDLE.
- Sticky outputs: done and error are never both 1, and they hold until the next accepted start.

Test Plan:
- Zero-wait slave, NUM_REGS=4, cfg words 0x1,0x2,0x3,0x4 -> writes to 0x0,0x4,0x8,0xC, readback matches; done=1 and error=0 exactly 25 cycles after the start pulse.
- AWREADY delayed 3 cycles while WREADY is immediate (and the reverse) -> WVALID drops after 1 cycle while AWVALID holds; no duplicate beat; sequence completes with done=1.
- Slave returns BRESP=2'b10 on register 2 -> error=1, err_code=01, err_index=2; no AR transaction issued.
- Slave corrupts readback of register 3 to 0xDEADBEEF -> error=1, err_code=10, err_index=3, done=0.
- ARREADY held low, TIMEOUT_CYCLES=16 -> ARVALID drops after 16 cycles; err_code=11, err_index=0, busy=0.
- ARESETN pulsed low during WR_RESP of register 1 -> all outputs 0 immediately; a following start reruns the full sequence from register 0 and ends with done=1.
- start pulsed while busy=1 -> ignored, with no change to the snapshot or sequence.
